// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - pipelined barrel shifter with valid/ready flow control and a side-band tag; rotate enabled by SHIFTER_ROTATE_EN
module pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAGW   = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [2:0]               shtype,
    input  logic [TAGW-1:0]          in_tag,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         y,
    output logic [TAGW-1:0]          out_tag
);

    localparam int SW = $clog2(WIDTH);

    // First shift level handled by stage s; stage s covers [lvl_lo(s), lvl_lo(s+1))
    function automatic int lvl_lo(input int s);
        return (SW * s + STAGES - 1) / STAGES;
    endfunction

    // One shift level: move x by 2^k according to the operation code
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x, input int k,
                                                     input logic [2:0] op, input logic sign);
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] fill;
        int               d;
        d    = 1 << k;
        fill = ~({WIDTH{1'b1}} >> d);
        case (op)
            3'b000:  r = x << d;
            3'b001:  r = x >> d;
            3'b010:  r = (x >> d) | (sign ? fill : '0);
`ifdef SHIFTER_ROTATE_EN
            3'b100:  r = (x << d) | (x >> (WIDTH - d));
            3'b101:  r = (x >> d) | (x << (WIDTH - d));
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    // Stage registers
    logic [WIDTH-1:0] d_q   [STAGES];
    logic [SW-1:0]    sh_q  [STAGES];
    logic [2:0]       op_q  [STAGES];
    logic             sg_q  [STAGES];
    logic [TAGW-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] v_q;

    // Stage inputs and the values each stage would capture
    logic [WIDTH-1:0] src_d   [STAGES];
    logic [SW-1:0]    src_sh  [STAGES];
    logic [2:0]       src_op  [STAGES];
    logic             src_sg  [STAGES];
    logic [TAGW-1:0]  src_tag [STAGES];
    logic             src_v   [STAGES];
    logic [WIDTH-1:0] nx_d    [STAGES];
    logic [STAGES-1:0] adv;

    // A stage may move when it or any stage downstream of it is empty, or the consumer takes the result
    for (genvar s = 0; s < STAGES; s++) begin : g_adv
        assign adv[s] = out_ready || !(&v_q[STAGES-1:s]);
    end

    assign in_ready  = adv[0] && !flush;
    assign out_valid = v_q[STAGES-1];
    assign y         = d_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];

    // Route each stage's source and apply that stage's share of the shift levels
    always_comb begin
        src_d[0]   = a;
        src_sh[0]  = shamt;
        src_op[0]  = shtype;
        src_sg[0]  = a[WIDTH-1];
        src_tag[0] = in_tag;
        src_v[0]   = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            src_d[s]   = d_q[s-1];
            src_sh[s]  = sh_q[s-1];
            src_op[s]  = op_q[s-1];
            src_sg[s]  = sg_q[s-1];
            src_tag[s] = tag_q[s-1];
            src_v[s]   = v_q[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            nx_d[s] = src_d[s];
            for (int k = 0; k < SW; k++) begin
                if (k >= lvl_lo(s) && k < lvl_lo(s + 1) && src_sh[s][k]) begin
                    nx_d[s] = shift_level(nx_d[s], k, src_op[s], src_sg[s]);
                end
            end
        end
    end

    // Pipeline registers: flush kills valids, data only loads when a stage advances with valid input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d_q[s]   <= '0;
                sh_q[s]  <= '0;
                op_q[s]  <= '0;
                sg_q[s]  <= 1'b0;
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (flush) begin
                    v_q[s] <= 1'b0;
                end else if (adv[s]) begin
                    v_q[s] <= src_v[s];
                    if (src_v[s]) begin
                        d_q[s]   <= nx_d[s];
                        sh_q[s]  <= src_sh[s];
                        op_q[s]  <= src_op[s];
                        sg_q[s]  <= src_sg[s];
                        tag_q[s] <= src_tag[s];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - scoreboard bench for pipe_shifter at STAGES 2, 1 and 5
module tb_pipe_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vi [3];
    logic        ir [3];
    logic        fl [3];
    logic        ov [3];
    logic        ordy [3];
    logic        acc [3];
    logic [31:0] ai [3];
    logic [31:0] yo [3];
    logic [31:0] exy [3];
    logic [4:0]  shi [3];
    logic [4:0]  tgi [3];
    logic [4:0]  tgo [3];
    logic [2:0]  tyi [3];
    logic [36:0] sb [3][$];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [2:0]  ty;
        logic [31:0] ex;
    } vec_t;
    vec_t vt[$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 5;
        pipe_shifter #(.WIDTH(32), .STAGES(ST), .TAGW(5)) u_dut (
            .clk       (clk),
            .reset     (rst),
            .in_valid  (vi[g]),
            .in_ready  (ir[g]),
            .a         (ai[g]),
            .shamt     (shi[g]),
            .shtype    (tyi[g]),
            .in_tag    (tgi[g]),
            .flush     (fl[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .y         (yo[g]),
            .out_tag   (tgo[g])
        );
    end

    function automatic int stg(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 5;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sh, input logic [2:0] ty);
        logic [31:0] r;
        case (ty)
            3'b000:  r = a << sh;
            3'b001:  r = a >> sh;
            3'b010:  r = $signed(a) >>> sh;
`ifdef SHIFTER_ROTATE_EN
            3'b100:  r = (sh == 0) ? a : ((a << sh) | (a >> (6'd32 - sh)));
            3'b101:  r = (sh == 0) ? a : ((a >> sh) | (a << (6'd32 - sh)));
`endif
            default: r = a;
        endcase
        return r;
    endfunction

    // Pop and compare every result the consumer accepts
    always @(negedge clk) begin
        logic [36:0] e;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (ov[d] && ordy[d]) begin
                    if (sb[d].size() == 0) begin
                        check($sformatf("extra_out%0d", d), 1, 0);
                    end else begin
                        e = sb[d].pop_front();
                        check($sformatf("y%0d", d), yo[d], e[31:0]);
                        check($sformatf("tag%0d", d), tgo[d], e[36:32]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            acc[d] = vi[d] && ir[d];
            if (acc[d]) sb[d].push_back({tgi[d], exy[d]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic [31:0] a, input logic [4:0] sh,
                         input logic [2:0] ty, input logic [4:0] tg, input logic [31:0] ex);
        vi[d]  = 1'b1;
        ai[d]  = a;
        shi[d] = sh;
        tyi[d] = ty;
        tgi[d] = tg;
        exy[d] = ex;
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [4:0] sh,
                         input logic [2:0] ty, input logic [4:0] tg, input logic [31:0] ex);
        int g;
        int lat;
        ordy[d] = 1'b1;
        drive(d, a, sh, ty, tg, ex);
        g = 0;
        do begin
            tick();
            g++;
        end while (!acc[d] && g < 50);
        check($sformatf("accept%0d", d), acc[d], 1);
        vi[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("latency%0d", d), lat, stg(d) - 1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            vi[d] = 0; fl[d] = 0; ordy[d] = 1; acc[d] = 0;
            ai[d] = 0; shi[d] = 0; tyi[d] = 0; tgi[d] = 0; exy[d] = 0;
        end
        vt.push_back('{32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000});
        vt.push_back('{32'h8000_0000, 5'd4,  3'b010, 32'hF800_0000});
        vt.push_back('{32'h8000_0000, 5'd4,  3'b001, 32'h0800_0000});
        vt.push_back('{32'h7FFF_FFFF, 5'd31, 3'b010, 32'h0000_0000});
`ifdef SHIFTER_ROTATE_EN
        vt.push_back('{32'h0000_00F1, 5'd4,  3'b101, 32'h1000_000F});
        vt.push_back('{32'h8000_0001, 5'd1,  3'b100, 32'h0000_0003});
`else
        vt.push_back('{32'h0000_00F1, 5'd4,  3'b101, 32'h0000_00F1});
        vt.push_back('{32'h8000_0001, 5'd1,  3'b100, 32'h8000_0001});
`endif
        vt.push_back('{32'hA5A5_A5A5, 5'd0,  3'b010, 32'hA5A5_A5A5});
        vt.push_back('{32'h1234_5678, 5'd7,  3'b011, 32'h1234_5678});
        vt.push_back('{32'hDEAD_BEEF, 5'd9,  3'b111, 32'hDEAD_BEEF});

        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ov%0d", d), ov[d], 0);
            check($sformatf("rst_y%0d", d), yo[d], 0);
            check($sformatf("rst_tag%0d", d), tgo[d], 0);
        end
        rst = 1'b0;
        #1;
        check("rst_ready", ir[0], 1);

        // Directed values and latency on every depth
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < vt.size(); i++) begin
                issue(d, vt[i].a, vt[i].sh, vt[i].ty, 5'(i + 1), vt[i].ex);
            end
        end

        // Stall with a full two-stage pipeline, then pass-through accept on release
        ordy[0] = 1'b0;
        drive(0, 32'h1, 5'd4, 3'b000, 5'd1, 32'h10);
        tick();
        drive(0, 32'h100, 5'd8, 3'b001, 5'd2, 32'h1);
        tick();
        check("full_ov", ov[0], 1);
        check("full_ready", ir[0], 0);
        drive(0, 32'hFFFF_FF00, 5'd4, 3'b010, 5'd3, 32'hFFFF_FFF0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hold_accept", acc[0], 0);
            check("hold_y", yo[0], 32'h10);
            check("hold_tag", tgo[0], 1);
        end
        ordy[0] = 1'b1;
        tick();
        check("passthru_accept", acc[0], 1);
        vi[0] = 1'b0;
        repeat (4) tick();

        // Flush two in-flight operations; an offer during flush must be refused
        ordy[0] = 1'b0;
        drive(0, 32'h7, 5'd1, 3'b000, 5'd7, 32'hE);
        tick();
        drive(0, 32'h8, 5'd1, 3'b000, 5'd8, 32'h10);
        tick();
        fl[0] = 1'b1;
        drive(0, 32'h3, 5'd1, 3'b000, 5'd9, 32'h6);
        #1;
        check("flush_ready", ir[0], 0);
        tick();
        fl[0] = 1'b0;
        sb[0].delete();
        check("flush_ov", ov[0], 0);
        tick();
        check("post_flush_accept", acc[0], 1);
        vi[0] = 1'b0;
        ordy[0] = 1'b1;
        repeat (4) tick();

        // Asynchronous reset between edges with a full pipeline
        ordy[0] = 1'b0;
        drive(0, 32'hF0, 5'd2, 3'b000, 5'd4, 32'h3C0);
        tick();
        drive(0, 32'hF0, 5'd3, 3'b000, 5'd5, 32'h780);
        tick();
        vi[0] = 1'b0;
        check("pre_reset_ov", ov[0], 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ov", ov[0], 0);
        check("async_rst_y", yo[0], 0);
        check("async_rst_tag", tgo[0], 0);
        for (int d = 0; d < 3; d++) sb[d].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        ordy[0] = 1'b1;

        // Random traffic with random back-pressure
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] ra;
                logic [4:0]  rs;
                logic [2:0]  rt;
                int g;
                ra = $urandom;
                rs = 5'($urandom_range(0, 31));
                rt = 3'($urandom_range(0, 7));
                drive(d, ra, rs, rt, 5'(i), model(ra, rs, rt));
                g = 0;
                do begin
                    ordy[d] = ($urandom_range(0, 3) != 0);
                    tick();
                    g++;
                end while (!acc[d] && g < 50);
                check("rand_accept", acc[d], 1);
            end
            vi[d] = 1'b0;
            ordy[d] = 1'b1;
            repeat (10) tick();
        end

        for (int d = 0; d < 3; d++) check($sformatf("drained%0d", d), sb[d].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
